mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to done (legal 1..15).
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of storage words (256 x 16-bit).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port addr  input  16  byte address from processor memory stage.
REQ-006 SHALL have port data_in  input  16  write data.
REQ-007 SHALL have port rd  input  1  read request.
REQ-008 SHALL have port wr  input  1  write request.
REQ-009 SHALL have port data_out  output  16  read data, valid only while done=1.
REQ-010 SHALL have port stall  output  1  processor must hold its pipeline.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port err  output  1  one-cycle illegal-request pulse.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL accept a request in IDLE or DONE when exactly one of rd/wr is 1 and addr[0]=0.
REQ-015 SHALL latch addr, data_in and op on acceptance, so processor inputs need not stay stable afterwards.
REQ-016 SHALL drive stall combinationally high in the accept cycle and every BUSY cycle, and low in IDLE and DONE unless a new request is accepted that cycle.
REQ-017 SHALL assert done exactly LATENCY cycles after the accept edge: accept at cycle 0 gives done at cycle LATENCY.
REQ-018 SHALL go directly from accept to DONE when LATENCY=1, with no BUSY cycle.
REQ-019 SHALL use a 4-bit down-counter loaded with LATENCY-1 on accept; BUSY exits to DONE when the counter reaches 0.
REQ-020 SHALL commit writes to storage on the edge entering DONE.
REQ-021 SHALL drive data_out = 0 in DONE for writes.
REQ-022 SHALL index storage with addr[DEPTH_LOG2:1]; higher address bits are ignored, so addresses wrap.
REQ-023 SHALL return the new data for a read following a write to the same word.
REQ-024 SHALL accept a request presented in the DONE cycle (back-to-back), giving done/stall timing identical to acceptance from IDLE.
REQ-025 SHALL flag an illegal request (rd&wr, or rd|wr with addr[0]=1) in IDLE/DONE: err=1 on the next cycle for one cycle, no storage access, no stall, state to IDLE.
REQ-026 SHALL ignore rd/wr while BUSY, with no err and no effect.
REQ-027 SHALL return DONE to IDLE after one cycle when no new request is accepted.

Reset
REQ-028 SHALL, on rst=0, asynchronously force state IDLE, counter 0, done 0, err 0 and data_out 0; stall SHALL then be 0.
REQ-029 SHALL abort an in-flight request on reset mid-operation with no storage write; storage contents are not cleared.

Structure
REQ-030 SHALL take its FSM state encoding and the LATENCY maximum (15) from shared package proc_mem_pkg.
REQ-031 SHALL instantiate one sub-module, mem_resp_array: a 2^DEPTH_LOG2 x 16 array with synchronous write and asynchronous read.

Verification
REQ-032 SHALL cover: wr addr 0x0010 data 0xBEEF, then rd 0x0010 -> read done at cycle 2 after accept, data_out=0xBEEF, stall high for 2 cycles.
REQ-033 SHALL cover: rd and wr both 1 at addr 0x0004 -> err=1 next cycle, stall=0, done never asserted, storage unchanged.
REQ-034 SHALL cover: rd addr 0x0003 -> err pulse, no done.
REQ-035 SHALL cover: wr 0x0202 data 0x1234 with DEPTH_LOG2=8, then rd 0x0002 -> 0x1234 (wrap).
REQ-036 SHALL cover: back-to-back reads presented in the DONE cycle with LATENCY=1 -> done high on consecutive cycles, each with correct data.
REQ-037 SHALL cover: rst=0 during BUSY of wr 0x0020 data 0xAAAA -> outputs 0 immediately, then rd 0x0020 returns the prior contents.

Source files
------------

// File: rtl/proc_mem_pkg.sv
// Shared definitions for the processor memory responder: FSM encoding and latency limits.
package proc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for the responder: synchronous write, asynchronous read, never reset.
module mem_resp_array
    import proc_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] widx,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] ridx,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for a processor memory stage: stalls the pipe,
// pulses done after LATENCY cycles, flags malformed requests with err.
//   state | meaning
//   IDLE  | no request in flight, ready to accept
//   BUSY  | request latched, latency counter running
//   DONE  | completion cycle: done=1, read data valid, may accept next request
module mem_responder
    import proc_mem_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd,
    input  logic              wr,
    output logic [DATA_W-1:0] data_out,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam int LAT_C = (LATENCY < 1) ? 1 : ((LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_C - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_dec;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d, widx;
    logic [DATA_W-1:0]       data_q, data_d, wdata, rdata;
    logic                    wop_q, wop_d;
    logic                    err_q, err_d;
    logic                    we, req, legal;

    // Address bits above the storage index are don't-care, so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:DEPTH_LOG2+1];

    assign req     = rd | wr;
    assign legal   = (rd ^ wr) & ~addr[0];
    assign cnt_dec = cnt_q - 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        wop_d   = wop_q;
        err_d   = 1'b0;
        stall   = 1'b0;
        we      = 1'b0;
        widx    = idx_q;
        wdata   = data_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (legal) begin
                    stall  = 1'b1;
                    idx_d  = addr[DEPTH_LOG2:1];
                    data_d = data_in;
                    wop_d  = wr;
                    if (LAT_C == 1) begin
                        // No BUSY phase: the write lands on the accept edge itself.
                        state_d = DONE;
                        we      = wr;
                        widx    = addr[DEPTH_LOG2:1];
                        wdata   = data_in;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end else if (req) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_dec;
                if (cnt_dec == '0) begin
                    state_d = DONE;
                    we      = wop_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            wop_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            wop_q   <= wop_d;
            err_q   <= err_d;
        end
    end

    mem_resp_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .widx  (widx),
        .wdata (wdata),
        .ridx  (idx_q),
        .rdata (rdata)
    );

    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign data_out = (state_q == DONE && !wop_q) ? rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=2, one at LATENCY=1.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic [15:0] addr0, din0, dout0, addr1, din1, dout1;
    logic        rd0, wr0, stall0, done0, err0;
    logic        rd1, wr1, stall1, done1, err1;

    int total;
    int passed;

    mem_responder #(.LATENCY(2), .DEPTH_LOG2(8)) dut (
        .clk(clk), .rst(rst), .addr(addr0), .data_in(din0), .rd(rd0), .wr(wr0),
        .data_out(dout0), .stall(stall0), .done(done0), .err(err0)
    );

    mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut1 (
        .clk(clk), .rst(rst), .addr(addr1), .data_in(din1), .rd(rd1), .wr(wr1),
        .data_out(dout1), .stall(stall1), .done(done1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit sel, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (sel) begin rd1 = r; wr1 = w; addr1 = a; din1 = d; end
        else     begin rd0 = r; wr0 = w; addr0 = a; din0 = d; end
    endtask

    // Starts a request one edge later, then scrambles the inputs so only latched values matter.
    task automatic run_op(input bit sel, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d,
                          output int done_cyc, output logic [15:0] dout, output int stall_cnt);
        @(posedge clk); #1;
        drive(sel, r, w, a, d);
        #1;
        stall_cnt = sel ? int'(stall1) : int'(stall0);
        done_cyc  = -1;
        dout      = 16'hxxxx;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive(sel, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
            #1;
            if (sel ? done1 : done0) begin
                done_cyc = c;
                dout     = sel ? dout1 : dout0;
                break;
            end
            stall_cnt += sel ? int'(stall1) : int'(stall0);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({done0, err0, stall0, dout0} !== 19'd0) $display("FAIL reset_outs: got %h expected 0", {done0, err0, stall0, dout0});
        else passed++;
        total++;
        if ({done1, err1, stall1, dout1} !== 19'd0) $display("FAIL reset_outs_lat1: got %h expected 0", {done1, err1, stall1, dout1});
        else passed++;
    endtask

    task automatic test_write_read();
        int dc, sc;
        logic [15:0] dv;
        run_op(1'b0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, dc, dv, sc);
        total++;
        if (dc !== 2) $display("FAIL wr_done_cycle: got %0d expected 2", dc); else passed++;
        total++;
        if (dv !== 16'h0000) $display("FAIL wr_data_out: got %h expected 0000", dv); else passed++;
        run_op(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, dc, dv, sc);
        total++;
        if (dc !== 2) $display("FAIL rd_done_cycle: got %0d expected 2", dc); else passed++;
        total++;
        if (dv !== 16'hBEEF) $display("FAIL rd_data: got %h expected beef", dv); else passed++;
        total++;
        if (sc !== 2) $display("FAIL rd_stall_cycles: got %0d expected 2", sc); else passed++;
        total++;
        if (stall0 !== 1'b0) $display("FAIL stall_in_done: got %b expected 0", stall0); else passed++;
        @(posedge clk); #2;
        total++;
        if ({done0, dout0} !== 17'd0) $display("FAIL done_to_idle: got %h expected 0", {done0, dout0}); else passed++;
    endtask

    task automatic test_illegal(input logic r, input logic w, input logic [15:0] a, input string nm);
        int dc, sc;
        logic [15:0] dv;
        logic seen_done;
        run_op(1'b0, 1'b0, 1'b1, a & 16'hFFFE, 16'h5555, dc, dv, sc);
        @(posedge clk); #1;
        drive(1'b0, r, w, a, 16'h0000);
        #1;
        total++;
        if ({stall0, err0} !== 2'b00) $display("FAIL %s_accept_cycle: got stall/err %b expected 00", nm, {stall0, err0}); else passed++;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        total++;
        if ({err0, stall0, done0} !== 3'b100) $display("FAIL %s_err_pulse: got err/stall/done %b expected 100", nm, {err0, stall0, done0}); else passed++;
        seen_done = 1'b0;
        @(posedge clk); #2;
        total++;
        if (err0 !== 1'b0) $display("FAIL %s_err_width: got %b expected 0", nm, err0); else passed++;
        for (int i = 0; i < 4; i++) begin
            seen_done |= done0;
            @(posedge clk); #2;
        end
        total++;
        if (seen_done !== 1'b0) $display("FAIL %s_no_done: got %b expected 0", nm, seen_done); else passed++;
        run_op(1'b0, 1'b1, 1'b0, a & 16'hFFFE, 16'h0000, dc, dv, sc);
        total++;
        if (dv !== 16'h5555) $display("FAIL %s_storage: got %h expected 5555", nm, dv); else passed++;
    endtask

    task automatic test_wrap();
        int dc, sc;
        logic [15:0] dv;
        run_op(1'b0, 1'b0, 1'b1, 16'h0202, 16'h1234, dc, dv, sc);
        run_op(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000, dc, dv, sc);
        total++;
        if (dv !== 16'h1234) $display("FAIL wrap_read: got %h expected 1234", dv); else passed++;
    endtask

    task automatic test_busy_ignore();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000);
        #1;
        total++;
        if (stall0 !== 1'b1) $display("FAIL busy_stall: got %b expected 1", stall0); else passed++;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        total++;
        if ({done0, err0, dout0} !== {2'b10, 16'hBEEF}) $display("FAIL busy_ignore: got %h expected %h", {done0, err0, dout0}, {2'b10, 16'hBEEF}); else passed++;
        @(posedge clk); #2;
        total++;
        if (err0 !== 1'b0) $display("FAIL busy_no_err: got %b expected 0", err0); else passed++;
    endtask

    task automatic test_back_to_back();
        int dc, sc;
        logic [15:0] dv;
        run_op(1'b1, 1'b0, 1'b1, 16'h0040, 16'h1111, dc, dv, sc);
        total++;
        if (dc !== 1) $display("FAIL lat1_done_cycle: got %0d expected 1", dc); else passed++;
        run_op(1'b1, 1'b0, 1'b1, 16'h0042, 16'h2222, dc, dv, sc);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000);
        #1;
        total++;
        if ({stall1, done1} !== 2'b10) $display("FAIL b2b_first_accept: got stall/done %b expected 10", {stall1, done1}); else passed++;
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 16'h0042, 16'h0000);
        #1;
        total++;
        if ({stall1, done1, dout1} !== {2'b11, 16'h1111}) $display("FAIL b2b_first_done: got %h expected %h", {stall1, done1, dout1}, {2'b11, 16'h1111}); else passed++;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        total++;
        if ({stall1, done1, dout1} !== {2'b01, 16'h2222}) $display("FAIL b2b_second_done: got %h expected %h", {stall1, done1, dout1}, {2'b01, 16'h2222}); else passed++;
        @(posedge clk); #2;
        total++;
        if (done1 !== 1'b0) $display("FAIL b2b_end: got %b expected 0", done1); else passed++;
    endtask

    task automatic test_reset_mid();
        int dc, sc;
        logic [15:0] dv;
        run_op(1'b0, 1'b0, 1'b1, 16'h0020, 16'h7777, dc, dv, sc);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 16'h0020, 16'hAAAA);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        total++;
        if (stall0 !== 1'b1) $display("FAIL midrst_busy: got %b expected 1", stall0); else passed++;
        rst = 1'b0;
        #1;
        total++;
        if ({stall0, done0, err0, dout0} !== 19'd0) $display("FAIL midrst_outs: got %h expected 0", {stall0, done0, err0, dout0}); else passed++;
        @(posedge clk); #1;
        rst = 1'b1;
        run_op(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, dc, dv, sc);
        total++;
        if (dv !== 16'h7777) $display("FAIL midrst_storage: got %h expected 7777", dv); else passed++;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst    = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #12;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        test_write_read();
        test_illegal(1'b1, 1'b1, 16'h0004, "rdwr_both");
        test_illegal(1'b1, 1'b0, 16'h0003, "misaligned");
        test_wrap();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
